// File: rtl/r88_pkg.sv
// Shared definitions for the r88 ALU sequencer.
// Op codes, sequencer state encoding and op classification helpers.
package r88_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    LATCH = 2'd2,
    DRIVE = 2'd3
  } seqState_t;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_AND  = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  function automatic logic isShift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  // Shifts and add/sub produce a carry the flag must track.
  function automatic logic carryOp(input logic [2:0] op);
    return (op >= OP_SHL) && (op <= OP_SUB);
  endfunction

endpackage

// File: rtl/r88_alu_seq.sv
// ALU operation sequencer: runs EXEC/LATCH/DRIVE per pass,
// repeating for multi-pass shifts, and owns the carry flag.
module r88_alu_seq
  import r88_pkg::*;
(
  input  logic       sysClock,
  input  logic       sysReset,
  input  logic       reqValid,
  output logic       reqReady,
  input  logic [2:0] reqOp,
  input  logic [2:0] reqCount,
  input  logic       reqCarryUse,
  input  logic       reqDec,
  input  logic       reqWide,
  input  logic       reqInv,
  input  logic       reqRightSel,
  output logic [2:0] aluOp,
  output logic       regLeft16,
  output logic       decMode,
  output logic       invOut,
  output logic       carryInEn,
  output logic       carryIn,
  output logic       rightSel,
  output logic       aluResult,
  output logic       loadResult,
  input  logic       carryOut,
  input  logic       flagSet,
  input  logic       flagClr,
  output logic       flagC,
  output logic       busy,
  output logic       done
);

  seqState_t state, stateNext;

  logic [2:0] hOp;
  logic [2:0] hCnt;
  logic       hCarryUse;
  logic       hDec;
  logic       hWide;
  logic       hInv;
  logic       hRightSel;
  logic       hFirst;
  logic       accept;
  logic       lastPass;
  logic       flagCapture;

  assign accept      = reqValid && reqReady;
  assign lastPass    = (hCnt == 3'd0);
  assign flagCapture = (state == EXEC) && carryOp(hOp) && !hWide;

  always_ff @(posedge sysClock or posedge sysReset) begin
    if (sysReset) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    reqReady   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    aluOp      = 3'd0;
    regLeft16  = 1'b0;
    decMode    = 1'b0;
    invOut     = 1'b0;
    carryInEn  = 1'b0;
    carryIn    = 1'b0;
    rightSel   = 1'b0;
    aluResult  = 1'b0;
    loadResult = 1'b0;
    if (state != IDLE) begin
      busy      = 1'b1;
      aluOp     = hOp;
      regLeft16 = hWide;
      decMode   = hDec && !hWide;
      invOut    = hInv && lastPass;
      carryInEn = hCarryUse;
      carryIn   = flagC;
      rightSel  = hFirst ? hRightSel : 1'b1;
    end
    unique case (state)
      IDLE: begin
        reqReady = !sysReset;
        if (accept) stateNext = EXEC;
      end
      EXEC: stateNext = LATCH;
      LATCH: begin
        loadResult = 1'b1;
        stateNext  = DRIVE;
      end
      DRIVE: begin
        aluResult = 1'b1;
        done      = lastPass;
        stateNext = lastPass ? IDLE : EXEC;
      end
    endcase
  end

  // hCnt holds passes remaining after the current one.
  always_ff @(posedge sysClock or posedge sysReset) begin
    if (sysReset) begin
      hOp       <= 3'd0;
      hCnt      <= 3'd0;
      hCarryUse <= 1'b0;
      hDec      <= 1'b0;
      hWide     <= 1'b0;
      hInv      <= 1'b0;
      hRightSel <= 1'b0;
      hFirst    <= 1'b0;
    end else if (accept) begin
      hOp       <= reqOp;
      hCnt      <= isShift(reqOp) ? reqCount : 3'd0;
      hCarryUse <= reqCarryUse;
      hDec      <= reqDec;
      hWide     <= reqWide;
      hInv      <= reqInv;
      hRightSel <= reqRightSel;
      hFirst    <= 1'b1;
    end else if (state == DRIVE && !lastPass) begin
      hCnt   <= hCnt - 3'd1;
      hFirst <= 1'b0;
    end
  end

  always_ff @(posedge sysClock or posedge sysReset) begin
    if (sysReset)         flagC <= 1'b0;
    else if (flagCapture) flagC <= carryOut;
    else if (flagSet)     flagC <= 1'b1;
    else if (flagClr)     flagC <= 1'b0;
  end

endmodule

// File: tb/tb_r88_alu_seq.sv
// Self-checking bench for r88_alu_seq: per-cycle model compare
// plus directed scenarios with literal expectations.
module tb_r88_alu_seq;

  logic       sysClock = 1'b0;
  logic       sysReset = 1'b1;
  logic       reqValid = 1'b0;
  logic       reqReady;
  logic [2:0] reqOp = 3'd0;
  logic [2:0] reqCount = 3'd0;
  logic       reqCarryUse = 1'b0;
  logic       reqDec = 1'b0;
  logic       reqWide = 1'b0;
  logic       reqInv = 1'b0;
  logic       reqRightSel = 1'b0;
  logic [2:0] aluOp;
  logic       regLeft16, decMode, invOut, carryInEn, carryIn;
  logic       rightSel, aluResult, loadResult;
  logic       carryOut = 1'b0;
  logic       flagSet = 1'b0;
  logic       flagClr = 1'b0;
  logic       flagC, busy, done;

  r88_alu_seq dut (
    .sysClock(sysClock), .sysReset(sysReset),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqOp(reqOp), .reqCount(reqCount),
    .reqCarryUse(reqCarryUse), .reqDec(reqDec),
    .reqWide(reqWide), .reqInv(reqInv),
    .reqRightSel(reqRightSel), .aluOp(aluOp),
    .regLeft16(regLeft16), .decMode(decMode),
    .invOut(invOut), .carryInEn(carryInEn),
    .carryIn(carryIn), .rightSel(rightSel),
    .aluResult(aluResult), .loadResult(loadResult),
    .carryOut(carryOut), .flagSet(flagSet),
    .flagClr(flagClr), .flagC(flagC),
    .busy(busy), .done(done)
  );

  always #5 sysClock = ~sysClock;

  typedef struct packed {
    logic       busy, done, load, res, exec;
    logic       l16, dec, inv, cen, rsel;
    logic [2:0] op;
  } rec_t;

  rec_t q[$];
  logic mFlag = 1'b0;
  int   nChecks = 0;
  int   nFail = 0;
  int   busyCnt = 0;
  int   loadCnt = 0;
  int   doneCnt = 0;

  wire [14:0] act = {reqReady, busy, done, aluOp,
                     regLeft16, decMode, invOut, carryInEn,
                     carryIn, rightSel, aluResult, loadResult,
                     flagC};

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Expected cycle records for a whole op, from the pass rules.
  function automatic int pushOp(
    input logic [2:0] op, cnt,
    input logic cu, dc, wd, iv, rs);
    int   n;
    rec_t r;
    n = (op == 3'd1 || op == 3'd2) ? int'(cnt) + 1 : 1;
    for (int p = 0; p < n; p++) begin
      for (int ph = 0; ph < 3; ph++) begin
        r      = '0;
        r.busy = 1'b1;
        r.op   = op;
        r.l16  = wd;
        r.dec  = dc && !wd;
        r.inv  = iv && (p == n - 1);
        r.cen  = cu;
        r.rsel = (p == 0) ? rs : 1'b1;
        r.exec = (ph == 0);
        r.load = (ph == 1);
        r.res  = (ph == 2);
        r.done = (ph == 2) && (p == n - 1);
        q.push_back(r);
      end
    end
    return n;
  endfunction

  always @(negedge sysClock) begin
    rec_t       r;
    logic [14:0] e;
    if (sysReset) begin
      q.delete();
      mFlag = 1'b0;
      check("resetOutputs", {17'd0, act}, 32'd0);
    end else begin
      r = (q.size() > 0) ? q.pop_front() : '0;
      e = {!r.busy, r.busy, r.done, r.op, r.l16, r.dec,
           r.inv, r.cen, r.busy & mFlag, r.rsel, r.res,
           r.load, mFlag};
      check("cycle", {17'd0, act}, {17'd0, e});
      if (busy) busyCnt++;
      if (loadResult) loadCnt++;
      if (done) doneCnt++;
      if (r.exec && r.op >= 3'd1 && r.op <= 3'd4 && !r.l16)
        mFlag = carryOut;
      else if (flagSet) mFlag = 1'b1;
      else if (flagClr) mFlag = 1'b0;
    end
  end

  task automatic doOp(
    input logic [2:0] op, cnt,
    input logic cu, dc, wd, iv, rs, co, hold);
    int n;
    reqOp = op; reqCount = cnt; reqCarryUse = cu;
    reqDec = dc; reqWide = wd; reqInv = iv;
    reqRightSel = rs; carryOut = co; reqValid = 1'b1;
    @(posedge sysClock); #1;
    if (!hold) reqValid = 1'b0;
    n = pushOp(op, cnt, cu, dc, wd, iv, rs);
    repeat (3 * n) @(posedge sysClock);
    #1;
  endtask

  int d0, b0, l0;

  initial begin
    repeat (2) @(posedge sysClock);
    #1 sysReset = 1'b0;
    @(posedge sysClock); #1;
    check("readyAfterReset", {31'd0, reqReady}, 32'd1);
    check("flagAfterReset", {31'd0, flagC}, 32'd0);

    d0 = doneCnt; b0 = busyCnt;
    doOp(3'd3, 3'd0, 0, 0, 0, 0, 0, 1, 0);
    check("addFlag", {31'd0, flagC}, 32'd1);
    check("addDone", doneCnt - d0, 1);
    check("addBusy", busyCnt - b0, 3);

    d0 = doneCnt; b0 = busyCnt; l0 = loadCnt;
    doOp(3'd1, 3'd2, 0, 0, 0, 1, 0, 0, 0);
    check("shlBusy", busyCnt - b0, 9);
    check("shlLoads", loadCnt - l0, 3);
    check("shlDone", doneCnt - d0, 1);
    check("shlFlag", {31'd0, flagC}, 32'd0);

    doOp(3'd3, 3'd0, 1, 1, 1, 0, 0, 1, 0);
    check("wideFlag", {31'd0, flagC}, 32'd0);

    reqOp = 3'd3; reqCount = 3'd0; reqCarryUse = 1'b0;
    reqDec = 1'b0; reqWide = 1'b0; reqInv = 1'b0;
    reqRightSel = 1'b0; carryOut = 1'b0; reqValid = 1'b1;
    @(posedge sysClock); #1;
    reqValid = 1'b0;
    void'(pushOp(3'd3, 3'd0, 0, 0, 0, 0, 0));
    flagSet = 1'b1;
    @(posedge sysClock); #1;
    check("execBeatsSet", {31'd0, flagC}, 32'd0);
    @(posedge sysClock); #1;
    check("setAlone", {31'd0, flagC}, 32'd1);
    flagSet = 1'b0; flagClr = 1'b1;
    @(posedge sysClock); #1;
    check("clrAlone", {31'd0, flagC}, 32'd0);
    flagSet = 1'b1;
    @(posedge sysClock); #1;
    check("setBeatsClr", {31'd0, flagC}, 32'd1);
    flagSet = 1'b0; flagClr = 1'b0;

    d0 = doneCnt;
    reqOp = 3'd2; reqCount = 3'd3; carryOut = 1'b1;
    reqValid = 1'b1;
    @(posedge sysClock); #1;
    reqValid = 1'b0;
    void'(pushOp(3'd2, 3'd3, 0, 0, 0, 0, 0));
    @(posedge sysClock); #1;
    check("inLatch", {31'd0, loadResult}, 32'd1);
    sysReset = 1'b1;
    #1;
    check("abortLoad", {31'd0, loadResult}, 32'd0);
    check("abortBusy", {31'd0, busy}, 32'd0);
    @(posedge sysClock); #1;
    sysReset = 1'b0;
    @(posedge sysClock); #1;
    check("abortReady", {31'd0, reqReady}, 32'd1);
    check("abortNoDone", doneCnt - d0, 0);
    check("abortFlag", {31'd0, flagC}, 32'd0);

    d0 = doneCnt; b0 = busyCnt;
    doOp(3'd5, 3'd4, 1, 0, 0, 1, 1, 0, 1);
    doOp(3'd7, 3'd0, 0, 1, 0, 0, 1, 0, 0);
    check("heldDone", doneCnt - d0, 2);
    check("heldBusy", busyCnt - b0, 6);

    for (int k = 0; k < 8; k++)
      doOp(3'(k), 3'(k), k[0], k[1], 1'b0, k[2], 1'b1,
           ~k[0], 1'b0);
    doOp(3'd4, 3'd0, 1, 1, 1, 1, 0, 1, 0);

    d0 = doneCnt; b0 = busyCnt;
    doOp(3'd2, 3'd7, 1, 0, 0, 1, 0, 1, 0);
    check("shr8Busy", busyCnt - b0, 24);
    check("shr8Done", doneCnt - d0, 1);

    repeat (2) @(posedge sysClock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
